mips_muldiv_alu: RTL and testbench

Parametrised next-generation execute-stage ALU for the mini-MIPS core. It pairs a combinational integer ALU with a sequential multiply/divide unit that owns the HI/LO register pair. The unit has a start/busy/done handshake, a pipelined multiplier of configurable depth and an iterative restoring divider. It sits in the EX stage; the control unit stalls the pipeline while `md_busy` is high.

---
 rtl/mips_muldiv_alu.sv | 192 +++++++++++++++++++
 tb/tb_mips_muldiv_alu.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_muldiv_alu.sv
// Execute-stage integer ALU plus a multi-cycle multiply/divide unit that owns HI/LO.
// Define MIPS_ALU_DIV_EN to build the restoring divider; without it DIV/DIVU complete at once as no-ops.
module mips_muldiv_alu #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2,
  parameter int SHW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] read2,
  input  logic [15:0]      immediate,
  input  logic             ALUSrc,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] ALU_result,
  output logic             zero,
  input  logic [2:0]       md_op,
  input  logic             md_start,
  output logic             md_busy,
  output logic             md_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int PW = 2 * WIDTH;
  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_MTHI = 3'b110;
  localparam logic [2:0] OP_MTLO = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DIV_FIX} state_t;

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } md_req_t;

  state_t  state;
  md_req_t req;
  logic    accept, mul_go, mul_acc;

  assign req    = '{op: md_op, a: data1, b: read2};
  assign accept = md_start && (state == S_IDLE);
  assign mul_go = accept && !req.op[2];

  // ---------------- combinational ALU ----------------
  logic [WIDTH-1:0] imm_ext, alu_b;

  assign imm_ext = WIDTH'($signed(immediate));
  assign alu_b   = ALUSrc ? imm_ext : read2;

  always_comb begin
    ALU_result = '0;
    case (alu_control)
      4'b0000: ALU_result = data1 & alu_b;
      4'b0001: ALU_result = data1 | alu_b;
      4'b0010: ALU_result = data1 + alu_b;
      4'b0110: ALU_result = data1 - alu_b;
      4'b0100: ALU_result = data1 ^ alu_b;
      4'b1100: ALU_result = ~(data1 | alu_b);
      4'b0111: ALU_result = WIDTH'($signed(data1) < $signed(alu_b));
      4'b1011: ALU_result = WIDTH'(data1 < alu_b);
      4'b1000: ALU_result = data1 << shamt;
      4'b1001: ALU_result = data1 >> shamt;
      4'b1010: ALU_result = $signed(data1) >>> shamt;
      default: ALU_result = '0;
    endcase
  end

  assign zero = (ALU_result == '0);

  // ---------------- multiplier pipeline ----------------
  // Operands are extended to 2*WIDTH so one unsigned multiply serves both signednesses.
  logic                           mul_sgn;
  logic [PW-1:0]                  mul_ea, mul_eb, mul_prod;
  logic [MUL_STAGES-1:0]          vld_pipe;
  logic [MUL_STAGES-1:0][PW-1:0]  prod_pipe;

  assign mul_sgn  = ~req.op[0];
  assign mul_ea   = mul_sgn ? PW'($signed(req.a)) : PW'(req.a);
  assign mul_eb   = mul_sgn ? PW'($signed(req.b)) : PW'(req.b);
  assign mul_prod = mul_ea * mul_eb;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= mul_go;
      for (int k = 1; k < MUL_STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (mul_go) prod_pipe[0] <= mul_prod;
    for (int k = 1; k < MUL_STAGES; k++)
      if (vld_pipe[k-1]) prod_pipe[k] <= prod_pipe[k-1];
  end

`ifdef MIPS_ALU_DIV_EN
  // ---------------- restoring divider datapath ----------------
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] dvd_raw, dvs_raw, dvs_abs, rem, quot;
  logic             div_sgn;
  logic [CW-1:0]    div_cnt;
  logic [WIDTH:0]   div_shift, div_diff;

  assign div_shift = {rem, quot[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, dvs_abs};

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? -v : v;
  endfunction
`endif

  // ---------------- control FSM, HI/LO ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      md_busy <= 1'b0;
      md_done <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      mul_acc <= 1'b0;
    end else begin
      md_done <= 1'b0;
      case (state)
        S_IDLE: if (md_start) begin
          case (req.op)
            OP_MTHI: begin hi <= req.a; md_done <= 1'b1; end
            OP_MTLO: begin lo <= req.a; md_done <= 1'b1; end
            OP_DIV, OP_DIVU: begin
`ifdef MIPS_ALU_DIV_EN
              state   <= S_DIV;
              md_busy <= 1'b1;
              dvd_raw <= req.a;
              dvs_raw <= req.b;
              div_sgn <= ~req.op[0];
              div_cnt <= '0;
`else
              md_done <= 1'b1;
`endif
            end
            default: begin
              state   <= S_MUL;
              md_busy <= 1'b1;
              mul_acc <= req.op[1];
            end
          endcase
        end
        S_MUL: if (vld_pipe[MUL_STAGES-1]) begin
          // MADD accumulates onto HI/LO as they stand at write time.
          {hi, lo} <= (mul_acc ? {hi, lo} : {PW{1'b0}}) + prod_pipe[MUL_STAGES-1];
          md_done  <= 1'b1;
          md_busy  <= 1'b0;
          state    <= S_IDLE;
        end
`ifdef MIPS_ALU_DIV_EN
        S_DIV: begin
          if (div_cnt == '0) begin
            quot    <= mag(dvd_raw, div_sgn);
            dvs_abs <= mag(dvs_raw, div_sgn);
            rem     <= '0;
          end else begin
            rem  <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            quot <= {quot[WIDTH-2:0], ~div_diff[WIDTH]};
            if (div_cnt == CW'(WIDTH)) state <= S_DIV_FIX;
          end
          div_cnt <= div_cnt + CW'(1);
        end
        S_DIV_FIX: begin
          // Zero divisor overrides the datapath; MIN/-1 falls out of the magnitude path naturally.
          if (dvs_raw == '0) begin
            lo <= '1;
            hi <= dvd_raw;
          end else begin
            lo <= (div_sgn && (dvd_raw[WIDTH-1] ^ dvs_raw[WIDTH-1])) ? -quot : quot;
            hi <= (div_sgn && dvd_raw[WIDTH-1]) ? -rem : rem;
          end
          md_done <= 1'b1;
          md_busy <= 1'b0;
          state   <= S_IDLE;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv_alu.sv
// Directed bench for mips_muldiv_alu: ALU vectors plus a HI/LO scoreboard for the multiply/divide unit.
module tb_mips_muldiv_alu;
  localparam int W  = 32;
  localparam int MS = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   alu_control;
  logic [W-1:0] data1, read2;
  logic [15:0]  immediate;
  logic         ALUSrc;
  logic [4:0]   shamt;
  logic [W-1:0] ALU_result;
  logic         zero;
  logic [2:0]   md_op;
  logic         md_start;
  logic         md_busy, md_done;
  logic [W-1:0] hi, lo;

  always #5 clk = ~clk;

  mips_muldiv_alu #(.WIDTH(W), .MUL_STAGES(MS)) dut (
    .clk(clk), .rst(rst), .alu_control(alu_control), .data1(data1), .read2(read2),
    .immediate(immediate), .ALUSrc(ALUSrc), .shamt(shamt), .ALU_result(ALU_result),
    .zero(zero), .md_op(md_op), .md_start(md_start), .md_busy(md_busy),
    .md_done(md_done), .hi(hi), .lo(lo)
  );

  typedef struct {
    string        tag;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] hi_m = '0, lo_m = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input string tag, input logic [3:0] ctl, input logic [W-1:0] a, b,
                     input logic src, input logic [15:0] imm, input logic [4:0] sh,
                     input logic [W-1:0] expv);
    alu_control = ctl; data1 = a; read2 = b; ALUSrc = src; immediate = imm; shamt = sh;
    #1;
    chk(tag, 64'(ALU_result), 64'(expv));
    chk({tag, "_zero"}, 64'(zero), 64'(expv == '0));
  endtask

  // Drives one start edge and pushes the expected HI/LO and done latency.
  task automatic issue(input string tag, input logic [2:0] op, input logic [W-1:0] a, b);
    exp_t          e;
    logic [63:0]   ps, pu;
    ps = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
    pu = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    e.tag = tag;
    e.lat = MS;
    case (op)
      3'd0: {hi_m, lo_m} = ps;
      3'd1: {hi_m, lo_m} = pu;
      3'd2: {hi_m, lo_m} = {hi_m, lo_m} + ps;
      3'd3: {hi_m, lo_m} = {hi_m, lo_m} + pu;
      3'd6: begin hi_m = a; e.lat = 0; end
      3'd7: begin lo_m = a; e.lat = 0; end
      default: begin
`ifdef MIPS_ALU_DIV_EN
        e.lat = W + 2;
        if (b == '0) begin
          lo_m = '1; hi_m = a;
        end else if (op == 3'd4 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lo_m = 32'h8000_0000; hi_m = '0;
        end else if (op == 3'd4) begin
          lo_m = 32'($signed(a) / $signed(b));
          hi_m = 32'($signed(a) % $signed(b));
        end else begin
          lo_m = a / b; hi_m = a % b;
        end
`else
        e.lat = 0;
`endif
      end
    endcase
    e.hi = hi_m;
    e.lo = lo_m;
    sb.push_back(e);
    md_op = op; data1 = a; read2 = b; md_start = 1'b1;
    tick();
    md_start = 1'b0;
  endtask

  // Called just after the start edge (cyc0 edges already elapsed); pops and compares.
  task automatic wait_done(input int cyc0);
    exp_t e;
    int   cyc, busy_gap;
    e = sb.pop_front();
    cyc = cyc0;
    busy_gap = 0;
    while (!md_done && cyc < 60) begin
      if (!md_busy) busy_gap++;
      tick();
      cyc++;
    end
    if (!md_done) begin
      checks++;
      errors++;
      $error("FAIL %s_timeout observed=no_done expected=done_at_%0d", e.tag, e.lat);
    end else begin
      chk({e.tag, "_lat"}, 64'(cyc), 64'(e.lat));
      chk({e.tag, "_hi"}, 64'(hi), 64'(e.hi));
      chk({e.tag, "_lo"}, 64'(lo), 64'(e.lo));
      chk({e.tag, "_busy_gap"}, 64'(busy_gap), 64'(0));
      chk({e.tag, "_busy_at_done"}, 64'(md_busy), 64'(0));
    end
  endtask

  task automatic count_done(input string tag, input int n);
    int d;
    d = 0;
    for (int i = 0; i < n; i++) begin
      if (md_done) d++;
      tick();
    end
    chk(tag, 64'(d), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; alu_control = '0; data1 = '0; read2 = '0; immediate = '0;
    ALUSrc = 1'b0; shamt = '0; md_op = '0; md_start = 1'b0;
    tick(); tick();
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    chk("rst_busy", 64'(md_busy), 64'(0));
    chk("rst_done", 64'(md_done), 64'(0));
    rst = 1'b0;

    alu("sub",  4'b0110, 32'd5,          32'd5,          1'b0, 16'h0,    5'd0, 32'h0000_0000);
    alu("nor",  4'b1100, 32'h0F0F_0F0F,  32'h0,          1'b0, 16'h0,    5'd0, 32'hF0F0_F0F0);
    alu("sra",  4'b1010, 32'h8000_0000,  32'h0,          1'b0, 16'h0,    5'd4, 32'hF800_0000);
    alu("srl",  4'b1001, 32'h8000_0000,  32'h0,          1'b0, 16'h0,    5'd4, 32'h0800_0000);
    alu("sll",  4'b1000, 32'h1,          32'h0,          1'b0, 16'h0,    5'd31, 32'h8000_0000);
    alu("sltu", 4'b1011, 32'd1,          32'hFFFF_FFFF,  1'b0, 16'h0,    5'd0, 32'd1);
    alu("slt",  4'b0111, 32'd1,          32'hFFFF_FFFF,  1'b0, 16'h0,    5'd0, 32'd0);
    alu("addi", 4'b0010, 32'd10,         32'd999,        1'b1, 16'hFFFE, 5'd0, 32'd8);
    alu("and",  4'b0000, 32'h0000_F0F0,  32'h0000_FF00,  1'b0, 16'h0,    5'd0, 32'h0000_F000);
    alu("or",   4'b0001, 32'h0000_F0F0,  32'h0000_FF00,  1'b0, 16'h0,    5'd0, 32'h0000_FFF0);
    alu("xor",  4'b0100, 32'h0000_F0F0,  32'h0000_FF00,  1'b0, 16'h0,    5'd0, 32'h0000_0FF0);
    alu("undef",4'b0011, 32'hFF,         32'hFF,         1'b0, 16'h0,    5'd0, 32'h0);
    ALUSrc = 1'b0;

    // MULT -3 x 7, with an MTLO attempted while busy that must be dropped
    issue("mult", 3'd0, 32'hFFFF_FFFD, 32'd7);
    chk("mult_busy_rise", 64'(md_busy), 64'(1));
    md_op = 3'd7; data1 = 32'h55; md_start = 1'b1;
    tick();
    md_start = 1'b0;
    wait_done(1);
    tick();
    chk("done_pulse_width", 64'(md_done), 64'(0));

    issue("mthi", 3'd6, 32'd0, 32'd0);
    wait_done(0);
    issue("mtlo", 3'd7, 32'd10, 32'd0);
    wait_done(0);
    issue("maddu", 3'd3, 32'hFFFF_FFFF, 32'd2);
    wait_done(0);
    issue("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(0);
    issue("mult_min", 3'd0, 32'h8000_0000, 32'h8000_0000);
    wait_done(0);
    issue("madd_neg", 3'd2, 32'hFFFF_FFFF, 32'd5);
    wait_done(0);

    issue("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2);
    wait_done(0);
    issue("divu_9_0", 3'd5, 32'd9, 32'd0);
    wait_done(0);
    issue("div_min_m1", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(0);
    issue("div_7_m2", 3'd4, 32'd7, 32'hFFFF_FFFE);
    wait_done(0);
    issue("divu_100_7", 3'd5, 32'd100, 32'd7);
    wait_done(0);
    tick();
    chk("idle_after_div_done", 64'(md_done), 64'(0));

    // reset one cycle into a multiply discards it
    issue("mtlo9", 3'd7, 32'd9, 32'd0);
    wait_done(0);
    issue("mul_abort", 3'd0, 32'd3, 32'd4);
    sb.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hi_m = '0; lo_m = '0;
    chk("mabort_busy", 64'(md_busy), 64'(0));
    chk("mabort_hi", 64'(hi), 64'(0));
    chk("mabort_lo", 64'(lo), 64'(0));
    count_done("mabort_no_done", 8);

`ifdef MIPS_ALU_DIV_EN
    issue("mthi5", 3'd6, 32'd5, 32'd0);
    wait_done(0);
    issue("div_abort", 3'd4, 32'd100, 32'd3);
    sb.delete();
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hi_m = '0; lo_m = '0;
    chk("dabort_busy", 64'(md_busy), 64'(0));
    chk("dabort_hi", 64'(hi), 64'(0));
    chk("dabort_lo", 64'(lo), 64'(0));
    count_done("dabort_no_done", 40);
`endif

    // reset and start on the same edge: reset wins
    md_op = 3'd7; data1 = 32'd77; md_start = 1'b1; rst = 1'b1;
    tick();
    md_start = 1'b0; rst = 1'b0;
    chk("rst_vs_start_lo", 64'(lo), 64'(0));
    chk("rst_vs_start_done", 64'(md_done), 64'(0));
    chk("rst_vs_start_busy", 64'(md_busy), 64'(0));

    issue("multu_after_rst", 3'd1, 32'd6, 32'd7);
    wait_done(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
